// File: rtl/i2s_receiver_if.sv
// Stereo sample handshake between the I2S receiver and the sample consumer.
interface i2s_receiver_if;
  logic [31:0] sample_left;
  logic [31:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples sck/ws/sd, deserialises MSB-first words and
// hands out one left/right pair per frame over a valid/ready handshake.
module i2s_receiver #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [3:0]     sample_size,
  input  logic           sck_in,
  input  logic           ws_in,
  input  logic           sd_in,
  input  logic           clr_err,
  i2s_receiver_if.master sample,
  output logic           overrun,
  output logic           frame_err,
  output logic           busy
);

  localparam int unsigned CNT_W    = 6;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned MAX_BITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sck_sync;
  logic [SYNC_STAGES-1:0]  ws_sync;
  logic [SYNC_STAGES-1:0]  sd_sync;
  logic                    sck_d;
  logic                    ws_prev;
  logic [WORD_W-1:0]       shreg;
  logic [WORD_W-1:0]       left_hold;
  logic                    left_ok;
  logic [CNT_W-1:0]        bit_cnt;

  logic                    sck_s_c;
  logic                    ws_s_c;
  logic                    sd_s_c;
  logic                    sck_rise_c;
  logic                    boundary_c;
  logic [CNT_W-1:0]        word_len_c;
  logic [CNT_W-1:0]        cnt_nxt_c;
  logic [WORD_W-1:0]       shreg_nxt_c;
  logic                    word_ok_c;

  // Pin synchronisers and sck edge history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_in};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_in};
      sck_d    <= sck_s_c;
    end
  end

  assign sck_s_c    = sck_sync[SYNC_STAGES-1];
  assign ws_s_c     = ws_sync[SYNC_STAGES-1];
  assign sd_s_c     = sd_sync[SYNC_STAGES-1];
  assign sck_rise_c = sck_s_c & ~sck_d;
  assign boundary_c = sck_rise_c && (ws_s_c != ws_prev);

  always_comb begin
    word_len_c = CNT_W'(MAX_BITS);
    case (sample_size)
      4'd0:    word_len_c = CNT_W'(8);
      4'd1:    word_len_c = CNT_W'(12);
      4'd3:    word_len_c = CNT_W'(16);
      4'd4:    word_len_c = CNT_W'(24);
      default: word_len_c = CNT_W'(MAX_BITS);
    endcase
  end

  // Bits beyond the word length are counted but not shifted in
  always_comb begin
    shreg_nxt_c = shreg;
    if (bit_cnt < word_len_c) shreg_nxt_c = {shreg[WORD_W-2:0], sd_s_c};
    cnt_nxt_c = (bit_cnt == CNT_W'(MAX_BITS)) ? bit_cnt : bit_cnt + CNT_W'(1);
    word_ok_c = (cnt_nxt_c >= word_len_c);
  end

  // Framing FSM, word capture, handshake and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      ws_prev             <= 1'b0;
      shreg               <= '0;
      left_hold           <= '0;
      left_ok             <= 1'b0;
      bit_cnt             <= '0;
      sample.sample_left  <= '0;
      sample.sample_right <= '0;
      sample.sample_valid <= 1'b0;
      overrun             <= 1'b0;
      frame_err           <= 1'b0;
      busy                <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (sample.sample_valid && sample.sample_ready) sample.sample_valid <= 1'b0;
      if (sck_rise_c) ws_prev <= ws_s_c;

      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= SYNC;
            busy  <= 1'b0;
          end
          SYNC: begin
            if (boundary_c && !ws_s_c) begin
              state   <= RUN;
              busy    <= 1'b1;
              shreg   <= '0;
              bit_cnt <= '0;
              left_ok <= 1'b0;
            end
          end
          RUN: begin
            if (sck_rise_c && !boundary_c) begin
              shreg   <= shreg_nxt_c;
              bit_cnt <= cnt_nxt_c;
            end else if (boundary_c) begin
              shreg   <= '0;
              bit_cnt <= '0;
              if (!word_ok_c || (!ws_prev && left_ok)) begin
                // Short word or a left word with no right word in between
                frame_err <= 1'b1;
                left_ok   <= 1'b0;
                state     <= SYNC;
                busy      <= 1'b0;
              end else if (!ws_prev) begin
                left_hold <= shreg_nxt_c;
                left_ok   <= 1'b1;
              end else begin
                left_ok <= 1'b0;
                if (left_ok) begin
                  if (!sample.sample_valid || sample.sample_ready) begin
                    sample.sample_left  <= left_hold;
                    sample.sample_right <= shreg_nxt_c;
                    sample.sample_valid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                end
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: builds I2S bit streams (sck = clk/8) and
// checks captured pairs, handshake and error flags with immediate assertions.
module tb_i2s_receiver;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] sample_size;
  logic       sck_in;
  logic       ws_in;
  logic       sd_in;
  logic       clr_err;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int vectors;
  int miscompares;

  bit          ch_q[$];
  bit          sd_q[$];
  logic [31:0] got_l[$];
  logic [31:0] got_r[$];
  bit          mon_en;

  i2s_receiver_if sif ();

  i2s_receiver #(.SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_size (sample_size),
    .sck_in      (sck_in),
    .ws_in       (ws_in),
    .sd_in       (sd_in),
    .clr_err     (clr_err),
    .sample      (sif),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted pair
  always @(negedge clk) begin
    if (mon_en && rst && sif.sample_valid && sif.sample_ready) begin
      got_l.push_back(sif.sample_left);
      got_r.push_back(sif.sample_right);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue one slot: nbits of w MSB-first, then slot-nbits pad bits
  task automatic push_word(input bit ch, input logic [31:0] w, input int nbits,
                           input int slot, input bit pad);
    for (int j = 0; j < slot; j++) begin
      ch_q.push_back(ch);
      sd_q.push_back((j < nbits) ? w[nbits-1-j] : pad);
    end
  endtask

  // ws leads data by one bit; optionally pulse ready on the edge that
  // processes the rise of bit ready_bit (third clk edge after sck rises)
  task automatic send(input bit next_ws, input int ready_bit);
    int n;
    n = ch_q.size();
    for (int k = 0; k < n; k++) begin
      ws_in  = (k + 1 < n) ? ch_q[k+1] : next_ws;
      sd_in  = sd_q[k];
      sck_in = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      sck_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (k == ready_bit && i == 1) sif.sample_ready = 1'b1;
        if (k == ready_bit && i == 2) sif.sample_ready = 1'b0;
      end
    end
    ch_q.delete();
    sd_q.delete();
  endtask

  task automatic accept();
    @(posedge clk); #1;
    sif.sample_ready = 1'b1;
    @(posedge clk); #1;
    sif.sample_ready = 1'b0;
    @(negedge clk);
    check("accept_valid_low", 32'(sif.sample_valid), 32'd0);
  endtask

  task automatic restart(input logic [3:0] size);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sample_size = size;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_l [3];
    logic [31:0] exp_r [3];
    vectors = 0;
    miscompares = 0;
    mon_en = 1'b0;
    rst = 1'b0;
    enable = 1'b0;
    sample_size = 4'd3;
    sck_in = 1'b0;
    ws_in = 1'b0;
    sd_in = 1'b0;
    clr_err = 1'b0;
    sif.sample_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_left", sif.sample_left, 32'd0);
    check("rst_right", sif.sample_right, 32'd0);
    check("rst_valid", 32'(sif.sample_valid), 32'd0);
    check("rst_flags", {29'd0, overrun, frame_err, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 16-bit, three back-to-back frames, consumer always ready
    restart(4'd3);
    exp_l[0] = 32'h0000A5C3; exp_r[0] = 32'h00001234;
    exp_l[1] = 32'h0000BEEF; exp_r[1] = 32'h0000CAFE;
    exp_l[2] = 32'h00000F0F; exp_r[2] = 32'h0000F0F0;
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    for (int f = 0; f < 3; f++) begin
      push_word(1'b0, exp_l[f], 16, 16, 1'b0);
      push_word(1'b1, exp_r[f], 16, 16, 1'b0);
    end
    mon_en = 1'b1;
    sif.sample_ready = 1'b1;
    send(1'b0, -1);
    sif.sample_ready = 1'b0;
    mon_en = 1'b0;
    @(negedge clk);
    check("b2b_count", 32'(got_l.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_l.size()) begin
        check("b2b_left", got_l[i], exp_l[i]);
        check("b2b_right", got_r[i], exp_r[i]);
      end
    end
    check("b2b_valid_low", 32'(sif.sample_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);

    // 24-bit words in 32-bit slots; right pad of ones must be ignored
    restart(4'd4);
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    push_word(1'b0, 32'h00ABCDEF, 24, 32, 1'b0);
    push_word(1'b1, 32'h00123456, 24, 32, 1'b1);
    send(1'b0, -1);
    @(negedge clk);
    check("w24_valid", 32'(sif.sample_valid), 32'd1);
    check("w24_left", sif.sample_left, 32'h00ABCDEF);
    check("w24_right", sif.sample_right, 32'h00123456);
    check("w24_frame_err", 32'(frame_err), 32'd0);
    accept();

    // Overrun: two 8-bit frames without ready
    restart(4'd0);
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    push_word(1'b0, 32'h11, 8, 8, 1'b0);
    push_word(1'b1, 32'h22, 8, 8, 1'b0);
    push_word(1'b0, 32'h33, 8, 8, 1'b0);
    push_word(1'b1, 32'h44, 8, 8, 1'b0);
    send(1'b0, -1);
    @(negedge clk);
    check("ovr_valid", 32'(sif.sample_valid), 32'd1);
    check("ovr_left", sif.sample_left, 32'h11);
    check("ovr_right", sif.sample_right, 32'h22);
    check("ovr_flag", 32'(overrun), 32'd1);
    @(posedge clk); #1;
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'd0);
    accept();

    // Ready lands exactly on the completion edge of frame 2
    restart(4'd0);
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    push_word(1'b0, 32'h5A, 8, 8, 1'b0);
    push_word(1'b1, 32'hA5, 8, 8, 1'b0);
    push_word(1'b0, 32'h3C, 8, 8, 1'b0);
    push_word(1'b1, 32'hC3, 8, 8, 1'b0);
    send(1'b0, 4 + 4 * 8 - 1);
    @(negedge clk);
    check("sim_valid", 32'(sif.sample_valid), 32'd1);
    check("sim_left", sif.sample_left, 32'h3C);
    check("sim_right", sif.sample_right, 32'hC3);
    check("sim_overrun", 32'(overrun), 32'd0);
    accept();

    // Short left word (12 of 16 bits), then resync on the next left word
    restart(4'd3);
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    push_word(1'b0, 32'h00000FFF, 12, 12, 1'b0);
    push_word(1'b1, 32'h00005555, 16, 16, 1'b0);
    send(1'b0, -1);
    @(negedge clk);
    check("short_frame_err", 32'(frame_err), 32'd1);
    check("short_valid", 32'(sif.sample_valid), 32'd0);
    check("short_busy", 32'(busy), 32'd1);
    push_word(1'b0, 32'h00008001, 16, 16, 1'b0);
    push_word(1'b1, 32'h00007FFE, 16, 16, 1'b0);
    send(1'b0, -1);
    @(negedge clk);
    check("resync_valid", 32'(sif.sample_valid), 32'd1);
    check("resync_left", sif.sample_left, 32'h00008001);
    check("resync_right", sif.sample_right, 32'h00007FFE);
    check("resync_frame_err", 32'(frame_err), 32'd1);

    // Asynchronous reset in the middle of a left word
    push_word(1'b0, 32'hF0, 8, 8, 1'b0);
    send(1'b0, -1);
    rst = 1'b0;
    #1;
    check("arst_left", sif.sample_left, 32'd0);
    check("arst_right", sif.sample_right, 32'd0);
    check("arst_valid", 32'(sif.sample_valid), 32'd0);
    check("arst_flags", {29'd0, overrun, frame_err, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // enable dropped mid-left-word; data resumes mid-frame
    push_word(1'b1, 32'h0, 4, 4, 1'b0);
    push_word(1'b0, 32'hDE, 8, 8, 1'b0);
    send(1'b0, -1);
    @(negedge clk);
    check("en_busy_run", 32'(busy), 32'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("en_busy_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    push_word(1'b0, 32'hAD, 8, 8, 1'b0);
    push_word(1'b1, 32'h0000BEEF, 16, 16, 1'b0);
    push_word(1'b0, 32'h00001357, 16, 16, 1'b0);
    push_word(1'b1, 32'h00002468, 16, 16, 1'b0);
    send(1'b0, -1);
    @(negedge clk);
    check("en_valid", 32'(sif.sample_valid), 32'd1);
    check("en_left", sif.sample_left, 32'h00001357);
    check("en_right", sif.sample_right, 32'h00002468);
    check("en_frame_err", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- I2S slave receiver: the receive-side counterpart of the team's I2S shift-register transmitter.
- Oversamples external bit clock (sck_in), word select (ws_in) and serial data (sd_in) in the system clock domain and deserialises MSB-first words.
- Delivers one left/right stereo pair per frame over a valid/ready handshake.
- Sits between the I2S pins (codec ADC or loopback from the transmitter) and the USB-side sample buffer.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on sck_in, ws_in and sd_in (minimum 2).

Ports:
- clk  input  1  system clock; must run at 4x the sck_in frequency or faster.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = receive; 0 = return to IDLE and discard any partial frame.
- sample_size  input  4  word length: 0=8, 1=12, 3=16, 4=24, 5=32 bits; any other value = 32 bits. Change only while enable=0.
- sck_in  input  1  I2S bit clock (asynchronous to clk).
- ws_in  input  1  I2S word select: 0 = left, 1 = right.
- sd_in  input  1  I2S serial data.
- sample_ready  input  1  consumer accepts the pair on a clk edge where sample_valid=1.
- clr_err  input  1  one-cycle pulse; clears overrun and frame_err.
- sample_left  output  32  left word, right-aligned and zero-extended.
- sample_right  output  32  right word, right-aligned and zero-extended.
- sample_valid  output  1  a stereo pair is held on sample_left/sample_right.
- overrun  output  1  sticky: a frame was dropped because the previous pair was not accepted.
- frame_err  output  1  sticky: a word ended with fewer than N bits.
- busy  output  1  1 in the RUN state.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all synchroniser flops 0, state IDLE, bit counter 0.
- Synchronisation:
  - sck_in, ws_in and sd_in each pass through SYNC_STAGES flops.
  - sck_rise = synchronised sck is 1 while its previous value was 0.
  - ws and sd are sampled only on clk cycles where sck_rise=1.
  - Pin-to-sample latency is SYNC_STAGES+1 clk.
- Word boundary: ws_prev holds the ws value from the previous sck_rise. A rise where ws differs from ws_prev is a boundary rise.
  - The sd bit sampled on the boundary rise is the LSB of the word that is ending.
  - The next rise carries the MSB of the new word (standard I2S one-bit delay).
- N = decoded sample_size. Within a word:
  - Bits shift in MSB-first while bit count < N; further bits are ignored.
  - The counter saturates at 32.
- Word end (on the boundary rise, after that rise's bit is included):
  - count >= N: the N-bit word is stored right-aligned in the channel holding register selected by ws_prev.
  - count < N: frame_err is set, the current frame is discarded, and the FSM waits for the next left word.
- FSM states:
  - IDLE: enable=0. Leaves to SYNC when enable=1.
  - SYNC: waits for the first boundary rise with new ws=0 (start of a left word), then goes to RUN. No data is captured before that.
  - RUN: captures words. enable=0 returns to IDLE in the next cycle, discarding partial data; sample_valid and the sticky flags are unaffected.
- Frame completion: a right word ends with count >= N and a good left word preceded it in the same frame.
  - sample_valid=0: load sample_left/sample_right and set sample_valid=1 on the same clk edge. This is 1 clk after the sck_rise detection.
  - sample_valid=1 and sample_ready=0: drop the new frame, keep the held pair, set overrun.
  - sample_valid=1 and sample_ready=1 on the same edge: load the new pair; sample_valid stays 1; no overrun.
- Handshake: sample_valid falls on the edge where sample_ready=1, unless a frame completes on that same edge. Outputs are stable while sample_valid=1.
- Sticky flags: cleared by clr_err. If clr_err coincides with a new error, the set wins.
- Two consecutive left words (a missing right word) count as a short right word: frame_err is set and the FSM resynchronises via SYNC.

Test Plan:
- 16-bit frames: sample_size=3, L=0xA5C3, R=0x1234, sck=clk/8 -> sample_left=0x0000A5C3, sample_right=0x00001234, sample_valid pulses until ready; 3 frames back-to-back all correct.
- 24-bit with a 32-sck slot: sample_size=4, L word 0xABCDEF padded with 8 zero bits -> sample_left=0x00ABCDEF, extra bits ignored, frame_err=0.
- Overrun: hold sample_ready=0 across two 8-bit frames (0x11/0x22, then 0x33/0x44) -> outputs stay 0x11/0x22 and overrun=1; clr_err -> overrun=0.
- Simultaneous completion and ready: ready asserted exactly on the completion edge of frame 2 -> frame 2 loaded, sample_valid stays 1, overrun=0.
- Short word: sample_size=3, ws toggles after 12 bits -> frame_err=1, no sample_valid; the next good frame is received correctly after resync.
- Reset and enable mid-word: pull rst low mid-left-word -> all outputs 0 immediately, without waiting for a clk edge. enable=0 mid-frame, then 1 -> first frame ignored until a fresh left word, then correct data.
